// File: rtl/stripe_sequencer.sv
// Job-level controller for one Stripe of eight PEs. It accepts a job descriptor,
// configures the Stripe, then fetches and broadcasts one operand block pair per
// iteration. Once the pipeline has drained, it writes the Stripe result block back.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
// After raising valid, the sender keeps valid and the payload stable until that
// edge. The block memory returns at most one response, in order, per accepted request.
module stripe_sequencer #(
  parameter int BLOCK_W   = 128,
  parameter int INSTR_W   = 7,
  parameter int TAG_W     = 12,
  parameter int DRAIN_CYC = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [INSTR_W+6*TAG_W-1:0] job_desc,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic [TAG_W-1:0]           mem_req_tag,
  input  logic                       mem_rsp_valid,
  input  logic [BLOCK_W-1:0]         mem_rsp_data,
  output logic                       wr_valid,
  input  logic                       wr_ready,
  output logic [TAG_W-1:0]           wr_tag,
  output logic [BLOCK_W-1:0]         wr_data,
  output logic                       s_cfg_we,
  output logic                       s_bus_valid,
  output logic [INSTR_W-1:0]         s_instr,
  output logic [TAG_W-1:0]           s_tag_a,
  output logic [TAG_W-1:0]           s_tag_b,
  output logic [TAG_W-1:0]           s_stride_a,
  output logic [TAG_W-1:0]           s_stride_b,
  output logic [TAG_W-1:0]           s_iter_lim,
  output logic [BLOCK_W-1:0]         s_d0,
  output logic [BLOCK_W-1:0]         s_d1,
  input  logic [BLOCK_W-1:0]         s_d_out,
  output logic                       busy,
  output logic                       done
);

  typedef enum logic [3:0] {
    S_IDLE, S_CFG, S_FETCH_A, S_WAIT_A, S_FETCH_B, S_WAIT_B,
    S_ISSUE, S_DRAIN, S_WRITE, S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [TAG_W-1:0]     tag_a_q, tag_a_d, tag_b_q, tag_b_d;
  logic [TAG_W-1:0]     stride_a_q, stride_a_d, stride_b_q, stride_b_d;
  logic [TAG_W-1:0]     iter_lim_q, iter_lim_d, out_tag_q, out_tag_d;
  logic [TAG_W-1:0]     cur_a_q, cur_a_d, cur_b_q, cur_b_d, k_q, k_d;
  logic [BLOCK_W-1:0]   buf_a_q, buf_a_d, buf_b_q, buf_b_d, wr_data_q, wr_data_d;
  logic [3:0]           drain_cnt_q, drain_cnt_d;

  // Every output is a flop. Its next value is decoded from the state being entered.
  logic                 job_ready_q, job_ready_d, busy_q, busy_d, done_q, done_d;
  logic                 mem_req_valid_q, mem_req_valid_d, wr_valid_q, wr_valid_d;
  logic                 s_cfg_we_q, s_cfg_we_d, s_bus_valid_q, s_bus_valid_d;
  logic [TAG_W-1:0]     mem_req_tag_q, mem_req_tag_d, wr_tag_q, wr_tag_d;
  logic [INSTR_W-1:0]   s_instr_q, s_instr_d;
  logic [TAG_W-1:0]     s_tag_a_q, s_tag_a_d, s_tag_b_q, s_tag_b_d;
  logic [TAG_W-1:0]     s_stride_a_q, s_stride_a_d, s_stride_b_q, s_stride_b_d;
  logic [TAG_W-1:0]     s_iter_lim_q, s_iter_lim_d;
  logic [BLOCK_W-1:0]   s_d0_q, s_d0_d, s_d1_q, s_d1_d;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    tag_a_d     = tag_a_q;
    tag_b_d     = tag_b_q;
    stride_a_d  = stride_a_q;
    stride_b_d  = stride_b_q;
    iter_lim_d  = iter_lim_q;
    out_tag_d   = out_tag_q;
    cur_a_d     = cur_a_q;
    cur_b_d     = cur_b_q;
    k_d         = k_q;
    buf_a_d     = buf_a_q;
    buf_b_d     = buf_b_q;
    wr_data_d   = wr_data_q;
    drain_cnt_d = drain_cnt_q;

    case (state_q)
      S_IDLE: begin
        // job_ready_q is the visible ready, so acceptance matches what the sender sees.
        if (job_valid && job_ready_q) begin
          {instr_d, tag_a_d, tag_b_d, stride_a_d, stride_b_d, iter_lim_d, out_tag_d} = job_desc;
          cur_a_d = tag_a_d;
          cur_b_d = tag_b_d;
          k_d     = '0;
          state_d = S_CFG;
        end
      end
      S_CFG: begin
        drain_cnt_d = '0;
        state_d     = (iter_lim_q == '0) ? S_DRAIN : S_FETCH_A;
      end
      S_FETCH_A: if (mem_req_ready) state_d = S_WAIT_A;
      S_WAIT_A: begin
        if (mem_rsp_valid) begin
          buf_a_d = mem_rsp_data;
          state_d = S_FETCH_B;
        end
      end
      S_FETCH_B: if (mem_req_ready) state_d = S_WAIT_B;
      S_WAIT_B: begin
        if (mem_rsp_valid) begin
          buf_b_d = mem_rsp_data;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Tag arithmetic wraps modulo 2^TAG_W by design.
        cur_a_d     = cur_a_q + stride_a_q;
        cur_b_d     = cur_b_q + stride_b_q;
        k_d         = k_q + 1'b1;
        drain_cnt_d = '0;
        state_d     = (k_d == iter_lim_q) ? S_DRAIN : S_FETCH_A;
      end
      S_DRAIN: begin
        if (drain_cnt_q == 4'(DRAIN_CYC - 1)) begin
          wr_data_d = s_d_out;
          state_d   = S_WRITE;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      S_WRITE: if (wr_ready) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    job_ready_d     = (state_d == S_IDLE);
    busy_d          = (state_d != S_IDLE);
    done_d          = (state_d == S_DONE);
    mem_req_valid_d = (state_d == S_FETCH_A) || (state_d == S_FETCH_B);
    mem_req_tag_d   = (state_d == S_FETCH_A) ? cur_a_d :
                      (state_d == S_FETCH_B) ? cur_b_d : '0;
    wr_valid_d      = (state_d == S_WRITE);
    wr_tag_d        = (state_d == S_WRITE) ? out_tag_d : '0;
    s_cfg_we_d      = (state_d == S_CFG);
    s_bus_valid_d   = (state_d == S_ISSUE);
    s_instr_d       = busy_d ? instr_d    : '0;
    s_stride_a_d    = busy_d ? stride_a_d : '0;
    s_stride_b_d    = busy_d ? stride_b_d : '0;
    s_iter_lim_d    = busy_d ? iter_lim_d : '0;
    s_tag_a_d       = (state_d == S_CFG) ? tag_a_d : (state_d == S_ISSUE) ? cur_a_d : '0;
    s_tag_b_d       = (state_d == S_CFG) ? tag_b_d : (state_d == S_ISSUE) ? cur_b_d : '0;
    s_d0_d          = (state_d == S_ISSUE) ? buf_a_d : '0;
    s_d1_d          = (state_d == S_ISSUE) ? buf_b_d : '0;
  end

  // State, datapath and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      instr_q         <= '0;
      tag_a_q         <= '0;
      tag_b_q         <= '0;
      stride_a_q      <= '0;
      stride_b_q      <= '0;
      iter_lim_q      <= '0;
      out_tag_q       <= '0;
      cur_a_q         <= '0;
      cur_b_q         <= '0;
      k_q             <= '0;
      buf_a_q         <= '0;
      buf_b_q         <= '0;
      wr_data_q       <= '0;
      drain_cnt_q     <= '0;
      job_ready_q     <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_req_tag_q   <= '0;
      wr_valid_q      <= 1'b0;
      wr_tag_q        <= '0;
      s_cfg_we_q      <= 1'b0;
      s_bus_valid_q   <= 1'b0;
      s_instr_q       <= '0;
      s_tag_a_q       <= '0;
      s_tag_b_q       <= '0;
      s_stride_a_q    <= '0;
      s_stride_b_q    <= '0;
      s_iter_lim_q    <= '0;
      s_d0_q          <= '0;
      s_d1_q          <= '0;
    end else begin
      state_q         <= state_d;
      instr_q         <= instr_d;
      tag_a_q         <= tag_a_d;
      tag_b_q         <= tag_b_d;
      stride_a_q      <= stride_a_d;
      stride_b_q      <= stride_b_d;
      iter_lim_q      <= iter_lim_d;
      out_tag_q       <= out_tag_d;
      cur_a_q         <= cur_a_d;
      cur_b_q         <= cur_b_d;
      k_q             <= k_d;
      buf_a_q         <= buf_a_d;
      buf_b_q         <= buf_b_d;
      wr_data_q       <= wr_data_d;
      drain_cnt_q     <= drain_cnt_d;
      job_ready_q     <= job_ready_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_tag_q   <= mem_req_tag_d;
      wr_valid_q      <= wr_valid_d;
      wr_tag_q        <= wr_tag_d;
      s_cfg_we_q      <= s_cfg_we_d;
      s_bus_valid_q   <= s_bus_valid_d;
      s_instr_q       <= s_instr_d;
      s_tag_a_q       <= s_tag_a_d;
      s_tag_b_q       <= s_tag_b_d;
      s_stride_a_q    <= s_stride_a_d;
      s_stride_b_q    <= s_stride_b_d;
      s_iter_lim_q    <= s_iter_lim_d;
      s_d0_q          <= s_d0_d;
      s_d1_q          <= s_d1_d;
    end
  end

  assign job_ready     = job_ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_tag   = mem_req_tag_q;
  assign wr_valid      = wr_valid_q;
  assign wr_tag        = wr_tag_q;
  assign wr_data       = wr_data_q;
  assign s_cfg_we      = s_cfg_we_q;
  assign s_bus_valid   = s_bus_valid_q;
  assign s_instr       = s_instr_q;
  assign s_tag_a       = s_tag_a_q;
  assign s_tag_b       = s_tag_b_q;
  assign s_stride_a    = s_stride_a_q;
  assign s_stride_b    = s_stride_b_q;
  assign s_iter_lim    = s_iter_lim_q;
  assign s_d0          = s_d0_q;
  assign s_d1          = s_d1_q;

endmodule
